// File: rtl/snitch_sb_issue_pkg.sv
// Shared types and constants for the FP scoreboard issue gate.
package snitch_sb_issue_pkg;

  // Number of addresses checked per instruction: rs1, rs2, rs3 and rd.
  localparam int unsigned SbNumTestAddrs = 4;

  typedef enum logic [1:0] {
    StEmpty,
    StCheck,
    StHazard,
    StBlocked
  } sb_issue_state_e;

  // RAW on any read source, or WAW on rd.
  function automatic logic sb_hazard(
    input logic [SbNumTestAddrs-1:0] present,
    input logic [2:0]                rs_used,
    input logic                      rd_used
  );
    return (|(present[2:0] & rs_used)) | (present[3] & rd_used);
  endfunction

endpackage

// File: rtl/snitch_sb_issue_oreg.sv
// One-entry valid/ready output register carrying the issued op and its one-hot tag.
module snitch_sb_issue_oreg
  import snitch_sb_issue_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DataWidth-1:0] in_op_i,
  input  logic [Depth-1:0]     in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_op_o,
  output logic [Depth-1:0]     out_tag_o
);

  // Refill in the same cycle the consumer drains, giving full throughput.
  assign in_ready_o = ~out_valid_o | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      out_op_o    <= '0;
      out_tag_o   <= '0;
    end else begin
      if (in_valid_i & in_ready_o) begin
        out_valid_o <= 1'b1;
        out_op_o    <= in_op_i;
        out_tag_o   <= in_tag_i;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/snitch_sb_issue.sv
// FPU issue gate: holds one FP instruction until the scoreboard reports no hazard.
// Optional stall perf counters enabled by defining SNITCH_SB_ISSUE_PERF_EN.
module snitch_sb_issue
  import snitch_sb_issue_pkg::*;
#(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [3*AddrWidth-1:0]              in_rs_i,
  input  logic [2:0]                          in_rs_used_i,
  input  logic [AddrWidth-1:0]                in_rd_i,
  input  logic                                in_rd_used_i,
  input  logic [DataWidth-1:0]                in_op_i,
  output logic [SbNumTestAddrs*AddrWidth-1:0] sb_test_addr_o,
  input  logic [SbNumTestAddrs-1:0]           sb_test_present_i,
  input  logic                                sb_full_i,
  input  logic [Depth-1:0]                    sb_entry_index_i,
  output logic [AddrWidth-1:0]                sb_push_addr_o,
  output logic                                sb_push_valid_o,
  output logic [Depth-1:0]                    sb_pop_index_o,
  output logic                                sb_pop_valid_o,
  output logic                                fpu_valid_o,
  input  logic                                fpu_ready_i,
  output logic [DataWidth-1:0]                fpu_op_o,
  output logic [Depth-1:0]                    fpu_tag_o,
  input  logic                                wb_valid_i,
  input  logic [Depth-1:0]                    wb_tag_i,
  output logic [CntWidth-1:0]                 stall_raw_cnt_o,
  output logic [CntWidth-1:0]                 stall_full_cnt_o
);

  sb_issue_state_e state;

  logic [3*AddrWidth-1:0] h_rs;
  logic [2:0]             h_rs_used;
  logic [AddrWidth-1:0]   h_rd;
  logic                   h_rd_used;
  logic [DataWidth-1:0]   h_op;

  logic h_valid;
  logic hazard;
  logic oreg_ready;
  logic can_issue;
  logic accept;
  logic [Depth-1:0] issue_tag;

  assign h_valid        = (state != StEmpty);
  assign sb_test_addr_o = {h_rd, h_rs};
  assign hazard         = sb_hazard(sb_test_present_i, h_rs_used, h_rd_used);

  // Ops without rd need no scoreboard slot, so a full scoreboard cannot block them.
  assign can_issue = h_valid & ~hazard & ~(h_rd_used & sb_full_i) & oreg_ready;

  // Flush never blocks an issue, but it does block a refill of the hold register.
  assign in_ready_o = ((state == StEmpty) | can_issue) & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;

  assign sb_push_valid_o = can_issue & h_rd_used;
  assign sb_push_addr_o  = h_rd;
  assign issue_tag       = h_rd_used ? sb_entry_index_i : '0;

  assign sb_pop_valid_o = wb_valid_i & (|wb_tag_i);
  assign sb_pop_index_o = wb_tag_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= StEmpty;
      h_rs      <= '0;
      h_rs_used <= '0;
      h_rd      <= '0;
      h_rd_used <= 1'b0;
      h_op      <= '0;
    end else begin
      if (accept) begin
        h_rs      <= in_rs_i;
        h_rs_used <= in_rs_used_i;
        h_rd      <= in_rd_i;
        h_rd_used <= in_rd_used_i;
        h_op      <= in_op_i;
      end
      if (can_issue) begin
        state <= accept ? StCheck : StEmpty;
      end else if (flush_i) begin
        state <= StEmpty;
      end else if (state == StEmpty) begin
        state <= accept ? StCheck : StEmpty;
      end else begin
        state <= hazard ? StHazard : StBlocked;
      end
    end
  end

  snitch_sb_issue_oreg #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) i_oreg (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (can_issue),
    .in_ready_o (oreg_ready),
    .in_op_i    (h_op),
    .in_tag_i   (issue_tag),
    .out_valid_o(fpu_valid_o),
    .out_ready_i(fpu_ready_i),
    .out_op_o   (fpu_op_o),
    .out_tag_o  (fpu_tag_o)
  );

`ifdef SNITCH_SB_ISSUE_PERF_EN
  logic [CntWidth-1:0] raw_cnt;
  logic [CntWidth-1:0] full_cnt;

  // Saturating stall counters; flush does not touch them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      raw_cnt  <= '0;
      full_cnt <= '0;
    end else begin
      if ((state == StHazard) && (raw_cnt != '1)) begin
        raw_cnt <= raw_cnt + CntWidth'(1);
      end
      if ((state == StBlocked) && (full_cnt != '1)) begin
        full_cnt <= full_cnt + CntWidth'(1);
      end
    end
  end

  assign stall_raw_cnt_o  = raw_cnt;
  assign stall_full_cnt_o = full_cnt;
`else
  assign stall_raw_cnt_o  = '0;
  assign stall_full_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snitch_sb_issue.sv
// Directed self-checking bench for snitch_sb_issue (default parameters).
module tb_snitch_sb_issue;

  localparam int AW = 5;
  localparam int D  = 4;
  localparam int DW = 32;
  localparam int CW = 32;

`ifdef SNITCH_SB_ISSUE_PERF_EN
  localparam int PerfEn = 1;
`else
  localparam int PerfEn = 0;
`endif

  logic            clk_i;
  logic            rst_ni;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [3*AW-1:0] in_rs_i;
  logic [2:0]      in_rs_used_i;
  logic [AW-1:0]   in_rd_i;
  logic            in_rd_used_i;
  logic [DW-1:0]   in_op_i;
  logic [4*AW-1:0] sb_test_addr_o;
  logic [3:0]      sb_test_present_i;
  logic            sb_full_i;
  logic [D-1:0]    sb_entry_index_i;
  logic [AW-1:0]   sb_push_addr_o;
  logic            sb_push_valid_o;
  logic [D-1:0]    sb_pop_index_o;
  logic            sb_pop_valid_o;
  logic            fpu_valid_o;
  logic            fpu_ready_i;
  logic [DW-1:0]   fpu_op_o;
  logic [D-1:0]    fpu_tag_o;
  logic            wb_valid_i;
  logic [D-1:0]    wb_tag_i;
  logic [CW-1:0]   stall_raw_cnt_o;
  logic [CW-1:0]   stall_full_cnt_o;

  int total = 0;
  int bad   = 0;

  snitch_sb_issue dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_rs_i          (in_rs_i),
    .in_rs_used_i     (in_rs_used_i),
    .in_rd_i          (in_rd_i),
    .in_rd_used_i     (in_rd_used_i),
    .in_op_i          (in_op_i),
    .sb_test_addr_o   (sb_test_addr_o),
    .sb_test_present_i(sb_test_present_i),
    .sb_full_i        (sb_full_i),
    .sb_entry_index_i (sb_entry_index_i),
    .sb_push_addr_o   (sb_push_addr_o),
    .sb_push_valid_o  (sb_push_valid_o),
    .sb_pop_index_o   (sb_pop_index_o),
    .sb_pop_valid_o   (sb_pop_valid_o),
    .fpu_valid_o      (fpu_valid_o),
    .fpu_ready_i      (fpu_ready_i),
    .fpu_op_o         (fpu_op_o),
    .fpu_tag_o        (fpu_tag_o),
    .wb_valid_i       (wb_valid_i),
    .wb_tag_i         (wb_tag_i),
    .stall_raw_cnt_o  (stall_raw_cnt_o),
    .stall_full_cnt_o (stall_full_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3*AW-1:0] rs, input logic [2:0] rs_used,
                               input logic [AW-1:0] rd, input logic rd_used, input logic [DW-1:0] op);
    in_valid_i   = v;
    in_rs_i      = rs;
    in_rs_used_i = rs_used;
    in_rd_i      = rd;
    in_rd_used_i = rd_used;
    in_op_i      = op;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni            = 1'b0;
    flush_i           = 1'b0;
    sb_test_present_i = '0;
    sb_full_i         = 1'b0;
    sb_entry_index_i  = 4'b0001;
    fpu_ready_i       = 1'b1;
    wb_valid_i        = 1'b0;
    wb_tag_i          = '0;
    applyStimulus(1'b0, '0, 3'b000, '0, 1'b0, '0);

    // reset state
    sample();
    checkOutput("rst_in_ready", 64'(in_ready_o), 64'd1);
    checkOutput("rst_fpu_valid", 64'(fpu_valid_o), 64'd0);
    checkOutput("rst_fpu_op", 64'(fpu_op_o), 64'd0);
    checkOutput("rst_fpu_tag", 64'(fpu_tag_o), 64'd0);
    checkOutput("rst_push_valid", 64'(sb_push_valid_o), 64'd0);
    checkOutput("rst_raw_cnt", 64'(stall_raw_cnt_o), 64'd0);
    nextCycle();
    rst_ni = 1'b1;

    // basic issue, empty scoreboard
    applyStimulus(1'b1, {5'd0, 5'd0, 5'd3}, 3'b001, 5'd5, 1'b1, 32'hA1);
    sample();
    checkOutput("t1_accept_ready", 64'(in_ready_o), 64'd1);
    checkOutput("t1_c0_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    in_valid_i = 1'b0;
    sample();
    checkOutput("t1_push_valid", 64'(sb_push_valid_o), 64'd1);
    checkOutput("t1_push_addr", 64'(sb_push_addr_o), 64'd5);
    checkOutput("t1_test_addr", 64'(sb_test_addr_o), 64'({5'd5, 5'd0, 5'd0, 5'd3}));
    checkOutput("t1_c1_fpu_valid", 64'(fpu_valid_o), 64'd0);
    nextCycle();
    sample();
    checkOutput("t1_fpu_valid", 64'(fpu_valid_o), 64'd1);
    checkOutput("t1_fpu_op", 64'(fpu_op_o), 64'hA1);
    checkOutput("t1_fpu_tag", 64'(fpu_tag_o), 64'b0001);
    checkOutput("t1_ready_again", 64'(in_ready_o), 64'd1);
    nextCycle();
    sample();
    checkOutput("t1_drained", 64'(fpu_valid_o), 64'd0);

    // RAW hazard on rs1 for four cycles
    sb_entry_index_i = 4'b0010;
    applyStimulus(1'b1, {5'd0, 5'd0, 5'd7}, 3'b001, 5'd8, 1'b1, 32'hB2);
    nextCycle();
    in_valid_i        = 1'b0;
    sb_test_present_i = 4'b0001;
    sample();
    checkOutput("t2_c1_push", 64'(sb_push_valid_o), 64'd0);
    checkOutput("t2_c1_in_ready", 64'(in_ready_o), 64'd0);
    nextCycle();
    sample();
    checkOutput("t2_c2_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    sample();
    checkOutput("t2_c3_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    wb_valid_i = 1'b1;
    wb_tag_i   = 4'b0010;
    sample();
    checkOutput("t2_c4_push", 64'(sb_push_valid_o), 64'd0);
    checkOutput("t2_pop_valid", 64'(sb_pop_valid_o), 64'd1);
    checkOutput("t2_pop_index", 64'(sb_pop_index_o), 64'b0010);
    nextCycle();
    sb_test_present_i = 4'b0000;
    wb_valid_i        = 1'b0;
    wb_tag_i          = '0;
    sample();
    checkOutput("t2_issue_push", 64'(sb_push_valid_o), 64'd1);
    checkOutput("t2_issue_addr", 64'(sb_push_addr_o), 64'd8);
    checkOutput("t2_pop_idle", 64'(sb_pop_valid_o), 64'd0);
    nextCycle();
    sample();
    checkOutput("t2_fpu_valid", 64'(fpu_valid_o), 64'd1);
    checkOutput("t2_fpu_op", 64'(fpu_op_o), 64'hB2);
    checkOutput("t2_fpu_tag", 64'(fpu_tag_o), 64'b0010);
    checkOutput("t2_raw_cnt", 64'(stall_raw_cnt_o), 64'(PerfEn * 4));
    nextCycle();

    // full scoreboard blocks an rd writer, flush it, then an rd-less op issues
    sb_full_i = 1'b1;
    applyStimulus(1'b1, '0, 3'b000, 5'd9, 1'b1, 32'hC3);
    nextCycle();
    in_valid_i = 1'b0;
    sample();
    checkOutput("t3_c1_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    sample();
    checkOutput("t3_blocked_ready", 64'(in_ready_o), 64'd0);
    checkOutput("t3_blocked_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    flush_i = 1'b1;
    sample();
    checkOutput("t3_flush_ready", 64'(in_ready_o), 64'd0);
    checkOutput("t3_flush_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    flush_i = 1'b0;
    applyStimulus(1'b1, '0, 3'b000, 5'd0, 1'b0, 32'hD4);
    sample();
    checkOutput("t3_after_flush_ready", 64'(in_ready_o), 64'd1);
    nextCycle();
    in_valid_i = 1'b0;
    sample();
    checkOutput("t3_norrd_push", 64'(sb_push_valid_o), 64'd0);
    checkOutput("t3_norrd_issue", 64'(in_ready_o), 64'd1);
    nextCycle();
    sample();
    checkOutput("t3_fpu_valid", 64'(fpu_valid_o), 64'd1);
    checkOutput("t3_fpu_op", 64'(fpu_op_o), 64'hD4);
    checkOutput("t3_fpu_tag", 64'(fpu_tag_o), 64'b0000);
    checkOutput("t3_full_cnt", 64'(stall_full_cnt_o), 64'(PerfEn * 2));
    nextCycle();
    sb_full_i = 1'b0;

    // FPU backpressure with two queued ops
    applyStimulus(1'b1, '0, 3'b000, 5'd0, 1'b0, 32'hE5);
    nextCycle();
    fpu_ready_i = 1'b0;
    applyStimulus(1'b1, '0, 3'b000, 5'd0, 1'b0, 32'hF6);
    sample();
    checkOutput("t4_second_accept", 64'(in_ready_o), 64'd1);
    nextCycle();
    in_valid_i = 1'b0;
    sample();
    checkOutput("t4_bp0_valid", 64'(fpu_valid_o), 64'd1);
    checkOutput("t4_bp0_op", 64'(fpu_op_o), 64'hE5);
    checkOutput("t4_held_ready", 64'(in_ready_o), 64'd0);
    nextCycle();
    sample();
    checkOutput("t4_bp1_op", 64'(fpu_op_o), 64'hE5);
    nextCycle();
    fpu_ready_i = 1'b1;
    sample();
    checkOutput("t4_bp2_op", 64'(fpu_op_o), 64'hE5);
    checkOutput("t4_bp2_valid", 64'(fpu_valid_o), 64'd1);
    nextCycle();
    sample();
    checkOutput("t4_second_valid", 64'(fpu_valid_o), 64'd1);
    checkOutput("t4_second_op", 64'(fpu_op_o), 64'hF6);
    checkOutput("t4_full_cnt", 64'(stall_full_cnt_o), 64'(PerfEn * 4));
    nextCycle();
    sample();
    checkOutput("t4_drained", 64'(fpu_valid_o), 64'd0);

    // push and pop in the same cycle
    sb_entry_index_i = 4'b1000;
    applyStimulus(1'b1, {5'd0, 5'd0, 5'd1}, 3'b001, 5'd10, 1'b1, 32'h77);
    nextCycle();
    in_valid_i = 1'b0;
    wb_valid_i = 1'b1;
    wb_tag_i   = 4'b0100;
    sample();
    checkOutput("t5_push_valid", 64'(sb_push_valid_o), 64'd1);
    checkOutput("t5_push_addr", 64'(sb_push_addr_o), 64'd10);
    checkOutput("t5_pop_valid", 64'(sb_pop_valid_o), 64'd1);
    checkOutput("t5_pop_index", 64'(sb_pop_index_o), 64'b0100);
    nextCycle();
    wb_tag_i = 4'b0000;
    sample();
    checkOutput("t5_zero_tag_pop", 64'(sb_pop_valid_o), 64'd0);
    checkOutput("t5_fpu_tag", 64'(fpu_tag_o), 64'b1000);
    checkOutput("t5_fpu_op", 64'(fpu_op_o), 64'h77);
    nextCycle();
    wb_valid_i = 1'b0;

    // flush while in HAZARD
    sb_entry_index_i = 4'b0001;
    applyStimulus(1'b1, {5'd0, 5'd4, 5'd0}, 3'b010, 5'd11, 1'b1, 32'h88);
    nextCycle();
    in_valid_i        = 1'b0;
    sb_test_present_i = 4'b0010;
    sample();
    checkOutput("t6_c1_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    flush_i = 1'b1;
    sample();
    checkOutput("t6_flush_push", 64'(sb_push_valid_o), 64'd0);
    checkOutput("t6_flush_ready", 64'(in_ready_o), 64'd0);
    nextCycle();
    flush_i           = 1'b0;
    sb_test_present_i = 4'b0000;
    sample();
    checkOutput("t6_empty_ready", 64'(in_ready_o), 64'd1);
    checkOutput("t6_no_push", 64'(sb_push_valid_o), 64'd0);
    checkOutput("t6_raw_cnt", 64'(stall_raw_cnt_o), 64'(PerfEn * 5));
    nextCycle();
    sample();
    checkOutput("t6_no_push_later", 64'(sb_push_valid_o), 64'd0);
    checkOutput("t6_no_fpu", 64'(fpu_valid_o), 64'd0);
    nextCycle();

    // async reset during a stall with the output register full
    applyStimulus(1'b1, '0, 3'b000, 5'd0, 1'b0, 32'h99);
    nextCycle();
    fpu_ready_i = 1'b0;
    applyStimulus(1'b1, {5'd0, 5'd0, 5'd2}, 3'b001, 5'd12, 1'b1, 32'hAA);
    sample();
    checkOutput("t7_accept", 64'(in_ready_o), 64'd1);
    nextCycle();
    in_valid_i        = 1'b0;
    sb_test_present_i = 4'b0001;
    sample();
    checkOutput("t7_fpu_valid", 64'(fpu_valid_o), 64'd1);
    nextCycle();
    rst_ni = 1'b0;
    #1;
    checkOutput("t7_rst_fpu_valid", 64'(fpu_valid_o), 64'd0);
    checkOutput("t7_rst_fpu_op", 64'(fpu_op_o), 64'd0);
    checkOutput("t7_rst_ready", 64'(in_ready_o), 64'd1);
    checkOutput("t7_rst_push", 64'(sb_push_valid_o), 64'd0);
    nextCycle();
    rst_ni            = 1'b1;
    sb_test_present_i = 4'b0000;
    fpu_ready_i       = 1'b1;
    sample();
    checkOutput("t7_post_rst_valid", 64'(fpu_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
